fnd_scan_controller: RTL
========================

Name: fnd_scan_controller

Overview:
Time-multiplexed scan controller for a 4-digit common-anode FND. Holds a 16-bit packed BCD value and rotates through the four digits. For each digit it drives the active-low digit-select and the BCD nibble/enable pair into the existing BCD-to-FND decoder, whose enable is blank-when-high. A dead-time blank phase at the start of each digit slot prevents ghosting. Value updates take effect only at frame boundaries, so a frame never shows a torn value.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot; must be > BLANK_CYCLES.
BLANK_CYCLES, 1000, dead-time cycles at the start of each slot; must be >= 1.

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  synchronous reset, active-low
i_Value  input  16  packed BCD; [3:0] = digit 0 (rightmost) ... [15:12] = digit 3
i_Load  input  1  capture strobe for i_Value, one cycle
o_Digit_Sel  output  4  digit commons, active-low, at most one bit low
o_Dec_Value  output  4  nibble to decoder i_Value
o_Dec_En  output  1  to decoder i_En; 1 = blank
o_Frame_Done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- One clock, i_clk. Reset is synchronous, active-low on i_reset_n, sampled on the rising edge.
- Reset values:
  - o_Digit_Sel = 4'b1111, o_Dec_En = 1, o_Dec_Value = 0, o_Frame_Done = 0.
  - Slot counter = 0, digit index = 0, phase = BLANK.
  - Display register = 0, hold register = 0, pending = 0.
- Reset asserted mid-frame takes effect on the next edge with no partial-state carry-over.
- Slot counter cnt runs 0..SCAN_DIV-1, width $clog2(SCAN_DIV). At SCAN_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
- Two-state FSM per slot:
  - BLANK while cnt < BLANK_CYCLES.
  - SHOW while cnt >= BLANK_CYCLES.
- All outputs are registered.
- BLANK phase outputs: o_Digit_Sel = 4'b1111, o_Dec_En = 1, o_Dec_Value = current digit nibble.
- SHOW phase outputs: o_Digit_Sel has bit[index] low and all other bits high; o_Dec_En = 0; o_Dec_Value = display nibble [4*index+3 : 4*index].
- After reset release, the first SHOW cycle of digit 0 appears at the output exactly BLANK_CYCLES edges after the first non-reset edge. Each slot is SCAN_DIV cycles: BLANK_CYCLES blank, then SCAN_DIV-BLANK_CYCLES shown. A frame is 4*SCAN_DIV cycles.
- Frame boundary is the edge where cnt = SCAN_DIV-1 and index = 3. That edge registers o_Frame_Done = 1 for exactly one cycle, coincident with the first BLANK cycle of digit 0.
- Load rules:
  - i_Load = 1 not on the boundary edge: hold <= i_Value, pending <= 1. Multiple loads within a frame: last wins.
  - At the boundary: if i_Load = 1 on that same edge, display <= i_Value directly. Else if pending = 1, display <= hold. pending <= 0 in both cases.
  - Display never changes at any other time.
- Nibbles 0xA..0xF pass through unmodified; the decoder defines their fonts.
- o_Digit_Sel never has more than one bit low in any cycle, including across slot transitions and reset.

Optional Feature:
FND_LZB_EN (leading-zero blanking).
- Defined: during SHOW, digit k (k = 1..3) is blanked when every display nibble at position >= k is 0x0. Blanked means o_Dec_En = 1 and o_Digit_Sel = 4'b1111 for the whole slot. Digit 0 is never blanked, so 0x0000 shows a single "0". Slot timing and o_Frame_Done are unchanged.
- Undefined: all four digits are always shown.

Test Plan:
1. SCAN_DIV=8, BLANK_CYCLES=2; hold i_reset_n=0 for 3 edges -> o_Digit_Sel=1111, o_Dec_En=1, o_Dec_Value=0, o_Frame_Done=0. Then reassert reset mid-slot of digit 2 -> next edge returns to digit 0 BLANK with cnt=0.
2. Load 0x1234 and wait one frame -> each slot shows 2 cycles of blank (1111, En=1), then 6 cycles of: 1110/value 4, 1101/value 3, 1011/value 2, 0111/value 1. o_Frame_Done pulses every 32 cycles.
3. Display 0x1234; pulse i_Load with 0x5678 during digit 1 SHOW, then 0x9999 during digit 2 -> rest of frame still shows 1234; next frame shows 9999.
4. i_Load with 0x4321 on the boundary edge while pending holds 0x9999 -> new frame shows 4321; pending cleared.
5. Monitor all cycles of tests 2-4 -> o_Digit_Sel never has two bits low; o_Dec_En=1 whenever o_Digit_Sel=1111.
6. With FND_LZB_EN defined:
   - 0x0105 -> digit 3 blanked; digits 2/1/0 show 1/0/5.
   - 0x0000 -> only digit 0 shows 0.
   - 0x0005 -> digits 1..3 blanked.
   - Without the macro, 0x0005 shows 0,0,0,5.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Scan controller for a 4-digit common-anode FND, with registered outputs and frame-atomic value updates.
// Define FND_LZB_EN to enable leading-zero blanking.
module fnd_scan_controller #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_Value,
    input  logic        i_Load,
    output logic [3:0]  o_Digit_Sel,
    output logic [3:0]  o_Dec_Value,
    output logic        o_Dec_En,
    output logic        o_Frame_Done
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {StBlank, StShow} phase_e;

    phase_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     display_q, display_d;
    logic [15:0]     hold_q, hold_d;
    logic            pending_q, pending_d;
    logic [3:0]      sel_q, sel_d;
    logic [3:0]      dec_val_q, dec_val_d;
    logic            dec_en_q, dec_en_d;
    logic            frame_done_q, frame_done_d;

    logic            slot_last;
    logic            boundary;
    logic            blank_lead;
    logic            show;

    always_comb begin
        slot_last = (cnt_q == CntW'(SCAN_DIV - 1));
        boundary  = slot_last && (idx_q == 2'd3);
        cnt_d     = slot_last ? '0 : cnt_q + CntW'(1);
        idx_d     = slot_last ? idx_q + 2'd1 : idx_q;

        state_d = state_q;
        unique case (state_q)
            StBlank: if (cnt_d == CntW'(BLANK_CYCLES)) state_d = StShow;
            StShow:  if (slot_last)                    state_d = StBlank;
            default: state_d = StBlank;
        endcase

        // The display only changes on the frame boundary; a boundary load bypasses hold.
        display_d = display_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        if (boundary) begin
            if (i_Load) begin
                display_d = i_Value;
            end else if (pending_q) begin
                display_d = hold_q;
            end
            pending_d = 1'b0;
        end else if (i_Load) begin
            hold_d    = i_Value;
            pending_d = 1'b1;
        end

`ifdef FND_LZB_EN
        blank_lead = ((idx_d == 2'd3) && (display_d[15:12] == 4'h0)) ||
                     ((idx_d == 2'd2) && (display_d[15:8]  == 8'h00)) ||
                     ((idx_d == 2'd1) && (display_d[15:4]  == 12'h000));
`else
        blank_lead = 1'b0;
`endif

        show         = (state_d == StShow) && !blank_lead;
        sel_d        = show ? ~(4'b0001 << idx_d) : 4'b1111;
        dec_en_d     = !show;
        dec_val_d    = display_d[4*idx_d +: 4];
        frame_done_d = boundary;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            display_q    <= 16'h0000;
            hold_q       <= 16'h0000;
            pending_q    <= 1'b0;
            sel_q        <= 4'b1111;
            dec_val_q    <= 4'h0;
            dec_en_q     <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            display_q    <= display_d;
            hold_q       <= hold_d;
            pending_q    <= pending_d;
            sel_q        <= sel_d;
            dec_val_q    <= dec_val_d;
            dec_en_q     <= dec_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_Digit_Sel  = sel_q;
    assign o_Dec_Value  = dec_val_q;
    assign o_Dec_En     = dec_en_q;
    assign o_Frame_Done = frame_done_q;

endmodule
